// File: rtl/i2c_pkg.sv
// Shared constants and types for the I2C byte-level master.
package i2c_pkg;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    localparam int unsigned QW = 2;
    localparam int unsigned SW = 4;
    localparam logic [SW-1:0] LAST_SLOT = SW'(8);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_WRITE,
        ST_READ
    } state_e;

endpackage

// File: rtl/i2c_master.sv
// I2C master executing one START/STOP/WRITE/READ command at a time on open-drain SCL/SDA controls.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned DW = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i,
    input  logic [7:0] data_in,
    input  logic       ack_in,
    input  logic [1:0] cmd,
    input  logic       stb,
    output logic [7:0] data_out,
    output logic       ack_out,
    output logic       ready
);

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [QW-1:0] qtr_q, qtr_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [7:0]    byte_q, byte_d;
    logic          ackin_q, ackin_d;
    logic [7:0]    dout_q, dout_d;
    logic          acko_q, acko_d;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;
    logic          ready_q, ready_d;
    logic          tick_c;

    assign tick_c = (div_q == {DW{1'b1}});

    // Next state, counters and line levels; line outputs follow the phase being entered.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        qtr_d   = qtr_q;
        slot_d  = slot_q;
        byte_d  = byte_q;
        ackin_d = ackin_q;
        dout_d  = dout_q;
        acko_d  = acko_q;
        scl_d   = scl_q;
        sda_d   = sda_q;

        if (state_q == ST_IDLE) begin
            if (stb) begin
                div_d   = '0;
                qtr_d   = '0;
                slot_d  = '0;
                byte_d  = data_in;
                ackin_d = ack_in;
                case (cmd)
                    CMD_START: state_d = ST_START;
                    CMD_STOP:  state_d = ST_STOP;
                    CMD_WRITE: state_d = ST_WRITE;
                    default:   state_d = ST_READ;
                endcase
            end
        end else begin
            div_d = div_q + DW'(1);
            if (tick_c) begin
                qtr_d = qtr_q + QW'(1);
                // End of Q2 is the sampling point while SCL is high.
                if (qtr_q == QW'(2)) begin
                    if (state_q == ST_WRITE && slot_q == LAST_SLOT) begin
                        acko_d = sda_i;
                    end
                    if (state_q == ST_READ && slot_q != LAST_SLOT) begin
                        dout_d = {dout_q[6:0], sda_i};
                    end
                end
                if (qtr_q == QW'(3)) begin
                    slot_d = slot_q + SW'(1);
                    if (state_q == ST_START || state_q == ST_STOP || slot_q == LAST_SLOT) begin
                        state_d = ST_IDLE;
                        slot_d  = '0;
                    end
                end
            end
        end

        case (state_d)
            ST_START: begin
                scl_d = (qtr_d == QW'(3));
                sda_d = qtr_d[1];
            end
            ST_STOP: begin
                scl_d = (qtr_d == QW'(0));
                sda_d = (qtr_d != QW'(3));
            end
            ST_WRITE: begin
                scl_d = (qtr_d == QW'(0)) || (qtr_d == QW'(3));
                sda_d = (slot_d == LAST_SLOT) ? 1'b0 : ~byte_d[3'(~slot_d)];
            end
            ST_READ: begin
                scl_d = (qtr_d == QW'(0)) || (qtr_d == QW'(3));
                sda_d = (slot_d == LAST_SLOT) ? ~ackin_d : 1'b0;
            end
            default: begin
                scl_d = scl_q;
                sda_d = sda_q;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            qtr_q   <= '0;
            slot_q  <= '0;
            byte_q  <= '0;
            ackin_q <= 1'b0;
            dout_q  <= '0;
            acko_q  <= 1'b0;
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            slot_q  <= slot_d;
            byte_q  <= byte_d;
            ackin_q <= ackin_d;
            dout_q  <= dout_d;
            acko_q  <= acko_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            ready_q <= ready_d;
        end
    end

    assign scl_oe   = scl_q;
    assign sda_oe   = sda_q;
    assign data_out = dout_q;
    assign ack_out  = acko_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master at DW=2 (quarter = 4 clk, bit slot = 16 clk).
module tb_i2c_master;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_oe, sda_oe, sda_i;
    logic [7:0] data_in, data_out;
    logic       ack_in, ack_out, ready, stb;
    logic [1:0] cmd;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n;
    int         lows;
    int         first_scl, first_sda;
    logic       scl_log [0:399];
    logic       sda_log [0:399];
    logic [8:0] sda_pat;

    always #5 clk = ~clk;

    i2c_master #(.DW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .sda_i    (sda_i),
        .data_in  (data_in),
        .ack_in   (ack_in),
        .cmd      (cmd),
        .stb      (stb),
        .data_out (data_out),
        .ack_out  (ack_out),
        .ready    (ready)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, scramble the inputs after acceptance, log lines per cycle while busy.
    task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic a,
                           input int stb_at, output int cnt);
        @(negedge clk);
        cmd = c; data_in = d; ack_in = a; stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0; data_in = ~d; ack_in = ~a; cmd = ~c;
        cnt = 0;
        while (ready == 1'b0 && cnt < 400) begin
            scl_log[cnt] = scl_oe;
            sda_log[cnt] = sda_oe;
            if (cnt < 144) sda_i = sda_pat[8 - cnt / 16];
            stb = (cnt == stb_at);
            cnt++;
            @(posedge clk); #1;
        end
        stb = 1'b0;
    endtask

    function automatic int sda_byte(input int off);
        logic [7:0] b;
        for (int s = 0; s < 8; s++) b[7 - s] = ~sda_log[s * 16 + off];
        return int'(b);
    endfunction

    initial begin
        rst = 1'b1; stb = 1'b0; cmd = 2'b00; data_in = 8'h00; ack_in = 1'b0;
        sda_i = 1'b1; sda_pat = '1;
        repeat (3) @(posedge clk); #1;
        chk("rst_scl", int'(scl_oe), 0);
        chk("rst_sda", int'(sda_oe), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_dout", int'(data_out), 0);
        chk("rst_ack", int'(ack_out), 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        run_cmd(CMD_START, 8'h00, 1'b0, -1, n);
        chk("start_len", n, 16);
        chk("start_q1", int'({scl_log[7], sda_log[7]}), 0);
        chk("start_q2", int'({scl_log[8], sda_log[8]}), 1);
        chk("start_q3", int'({scl_log[12], sda_log[12]}), 3);
        chk("start_end", int'({ready, scl_oe, sda_oe}), 7);

        sda_pat = 9'h1FF;
        run_cmd(CMD_WRITE, 8'h5A, 1'b0, -1, n);
        chk("w5a_bits", sda_byte(4), 8'h5A);
        chk("w5a_nack", int'(ack_out), 1);

        sda_pat = 9'h1FE;
        run_cmd(CMD_WRITE, 8'hA5, 1'b0, -1, n);
        chk("wa5_len", n, 144);
        chk("wa5_bits", sda_byte(4), 8'hA5);
        chk("wa5_setup", sda_byte(0), 8'hA5);
        chk("wa5_scl", int'({scl_log[48], scl_log[52], scl_log[56], scl_log[60]}), 4'b1001);
        chk("wa5_s8_rel", int'(sda_log[132]), 0);
        chk("wa5_ack", int'(ack_out), 0);
        chk("wa5_end", int'({ready, scl_oe, sda_oe}), 6);

        sda_pat = {8'h3C, 1'b1};
        run_cmd(CMD_READ, 8'h00, 1'b1, -1, n);
        chk("r3c_len", n, 144);
        chk("r3c_data", int'(data_out), 8'h3C);
        chk("r3c_rel", int'(sda_log[4]), 0);
        chk("r3c_s8", int'(sda_log[132]), 0);

        sda_pat = {8'hC3, 1'b1};
        run_cmd(CMD_READ, 8'h00, 1'b0, -1, n);
        chk("rc3_data", int'(data_out), 8'hC3);
        chk("rc3_s8", int'(sda_log[132]), 1);
        chk("rc3_end", int'({scl_oe, sda_oe}), 3);

        // Strobe (a STOP) while a WRITE is busy must be ignored.
        sda_pat = 9'h1FF;
        run_cmd(CMD_WRITE, 8'h0F, 1'b0, 40, n);
        chk("busy_len", n, 144);
        lows = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready == 1'b0) lows++;
        end
        chk("busy_ignored", lows, 0);
        chk("busy_scl", int'(scl_oe), 1);

        run_cmd(CMD_STOP, 8'h00, 1'b0, -1, n);
        chk("stop_len", n, 16);
        chk("stop_q0", int'({scl_log[0], sda_log[0]}), 3);
        chk("stop_q1", int'({scl_log[4], sda_log[4]}), 1);
        chk("stop_q3", int'({scl_log[12], sda_log[12]}), 0);
        first_scl = -1; first_sda = -1;
        for (int i = 0; i < 16; i++) begin
            if (first_scl < 0 && scl_log[i] == 1'b0) first_scl = i;
            if (first_sda < 0 && sda_log[i] == 1'b0) first_sda = i;
        end
        chk("stop_order", int'(first_sda > first_scl), 1);
        chk("stop_end", int'({ready, scl_oe, sda_oe}), 4);

        // Asynchronous reset in the middle of a WRITE.
        @(negedge clk);
        cmd = CMD_WRITE; data_in = 8'h00; ack_in = 1'b0; stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        repeat (35) @(posedge clk);
        #3;
        chk("mid_busy", int'({ready, scl_oe, sda_oe}), 3);
        rst = 1'b1;
        #1;
        chk("abort_lines", int'({scl_oe, sda_oe}), 0);
        chk("abort_ready", int'(ready), 1);
        chk("abort_dout", int'(data_out), 0);
        chk("abort_ack", int'(ack_out), 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        run_cmd(CMD_START, 8'h00, 1'b0, -1, n);
        chk("restart_len", n, 16);
        chk("restart_end", int'({ready, scl_oe, sda_oe}), 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter DW, default 4: clock-divider width; one quarter-bit period Q = 2^DW clk cycles.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 scl_oe  output  1  1 drives SCL low; 0 releases SCL.
REQ-005 sda_oe  output  1  1 drives SDA low; 0 releases SDA.
REQ-006 sda_i  input  1  sampled SDA pad level.
REQ-007 data_in  input  8  byte for WRITE.
REQ-008 ack_in  input  1  ACK bit for READ; 0 means ACK.
REQ-009 cmd  input  2  command: 00 START, 01 STOP, 10 WRITE, 11 READ.
REQ-010 stb  input  1  command strobe, one cycle.
REQ-011 data_out  output  8  byte received by READ.
REQ-012 ack_out  output  1  ACK sampled by WRITE; 0 means ACK.
REQ-013 ready  output  1  1 = idle, able to accept a command.

Function
REQ-014 Outputs are open-drain controls only; the block never drives a line high.
REQ-015 A command is accepted on a cycle with stb=1 and ready=1; stb with ready=0 is ignored.
REQ-016 ready goes low on the cycle after acceptance and returns high when the command's last quarter ends.
REQ-017 Quarter tick: DW-bit counter cleared on acceptance; a tick is generated every 2^DW cycles while busy.
REQ-018 START takes 4Q: Q0-Q1 release SDA and SCL; Q2 SDA low; Q3 SCL low.
REQ-019 STOP takes 4Q: Q0 SDA low with SCL low; Q1-Q2 SCL released; Q3 SDA released.
REQ-020 WRITE and READ each take 9 bit slots of 4Q, 36Q in total.
REQ-021 Bit slot: Q0 SCL low and SDA set up; Q1-Q2 SCL released; sample sda_i at the end of Q2; Q3 SCL low.
REQ-022 WRITE slots 0-7 drive data_in MSB first, with sda_oe = ~bit.
REQ-023 WRITE slot 8 releases SDA and latches sda_i into ack_out.
REQ-024 READ slots 0-7 release SDA and shift sda_i into data_out MSB first.
REQ-025 READ slot 8 drives sda_oe = ~ack_in.
REQ-026 data_in, cmd and ack_in are captured at acceptance; later changes have no effect.
REQ-027 After START, WRITE and READ, SCL stays low (scl_oe=1) and SDA keeps its last value until the next command.
REQ-028 After STOP, both lines stay released.
REQ-029 data_out and ack_out change only as defined in REQ-023/REQ-024 and hold otherwise.
REQ-030 No clock stretching or arbitration; SCL is not sampled.

Reset
REQ-031 While rst=1: scl_oe=0, sda_oe=0, ready=1, data_out=0, ack_out=0, and the divider and bit counters are 0.
REQ-032 rst asserted mid-command aborts the command immediately, releases both lines and returns to idle.

Structure
REQ-033 Command encodings (START/STOP/WRITE/READ) are constants in a shared package i2c_pkg.
REQ-034 Single module; the FSM has states IDLE, START, STOP, WRITE, READ, plus 2-bit quarter and 4-bit slot counters.
REQ-035 No sub-module; pads and SB_IO instances are outside this block.

Verification
REQ-036 DW=2, reset then START: ready low for exactly 16 cycles; SDA falls while SCL released, then SCL low.
REQ-037 DW=2, WRITE 0xA5 with sda_i=0 in slot 8: SDA pattern 1,0,1,0,0,1,0,1; ready low 144 cycles; ack_out=0.
REQ-038 DW=2, READ with sda_i pattern 0x3C and ack_in=1: data_out=0x3C; SDA released in slot 8.
REQ-039 STOP after WRITE: final state scl_oe=0 and sda_oe=0, with SDA released after SCL.
REQ-040 stb during busy plus rst pulse mid-WRITE: the extra stb is ignored; after reset, lines are released and ready=1 immediately.
